// File: rtl/ddr4_rx_lane_aligner.sv
// DDR4 receive lane aligner: trains word alignment with IOD bit-slip against an
// MPR pattern, measures read latency, then qualifies read words with a valid strobe.
module ddr4_rx_lane_aligner #(
    parameter logic [7:0] TRAIN_PATTERN = 8'h3C,
    parameter int         MATCH_COUNT   = 4,
    parameter int         SLIP_WAIT     = 4,
    parameter int         RL_MAX        = 15
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic [7:0] RX_DATA,
    input  logic       TRAIN_START,
    input  logic       RD_ISSUE,
    output logic       RX_BIT_SLIP,
    output logic [7:0] RD_DATA,
    output logic       RD_VALID,
    output logic [3:0] RD_LATENCY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_FAIL,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ALIGN     = 3'd1,
        ST_SLIP      = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_LAT_ARM   = 3'd4,
        ST_LAT_COUNT = 3'd5,
        ST_DONE      = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    localparam logic [3:0] MATCH_TGT  = 4'(MATCH_COUNT);
    localparam logic [3:0] WAIT_LAST  = 4'(SLIP_WAIT - 1);
    localparam logic [3:0] LAT_LAST   = 4'(RL_MAX);
    localparam logic [2:0] SLIP_LIMIT = 3'd7;

    state_t              state_q, state_d;
    logic [2:0]          slip_cnt_q, slip_cnt_d;
    logic [3:0]          match_cnt_q, match_cnt_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [3:0]          lat_cnt_q, lat_cnt_d;
    logic [3:0]          rd_latency_q, rd_latency_d;
    logic                train_done_q, train_done_d;
    logic                train_fail_q, train_fail_d;
    logic                busy_q, busy_d;
    logic                rx_bit_slip_q, rx_bit_slip_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [RL_MAX-1:0]   vpipe_q, vpipe_d;

    logic                pat_hit_s;
    logic [3:0]          match_inc_s;
    logic                restart_s;
    logic                tap_s;

    assign pat_hit_s   = (RX_DATA == TRAIN_PATTERN);
    assign match_inc_s = match_cnt_q + 4'd1;

    // Training FSM next-state and training result registers
    always_comb begin
        state_d       = state_q;
        slip_cnt_d    = slip_cnt_q;
        match_cnt_d   = match_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        rd_latency_d  = rd_latency_q;
        train_done_d  = train_done_q;
        train_fail_d  = train_fail_q;
        rx_bit_slip_d = 1'b0;
        restart_s     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (TRAIN_START) begin
                    restart_s    = 1'b1;
                    train_done_d = 1'b0;
                    train_fail_d = 1'b0;
                    slip_cnt_d   = 3'd0;
                    match_cnt_d  = 4'd0;
                    state_d      = ST_ALIGN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ALIGN: begin
                if (pat_hit_s) begin
                    match_cnt_d = match_inc_s;
                    if (match_inc_s == MATCH_TGT) begin
                        state_d = ST_LAT_ARM;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end else begin
                    match_cnt_d = 4'd0;
                    // Seven slips have covered every other rotation of the word
                    if (slip_cnt_q == SLIP_LIMIT) begin
                        train_fail_d = 1'b1;
                        state_d      = ST_FAIL;
                    end else begin
                        rx_bit_slip_d = 1'b1;
                        state_d       = ST_SLIP;
                    end
                end
            end
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 3'd1;
                wait_cnt_d = 4'd0;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ALIGN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_LAT_ARM: begin
                if (RD_ISSUE) begin
                    lat_cnt_d = 4'd1;
                    state_d   = ST_LAT_COUNT;
                end else begin
                    state_d = ST_LAT_ARM;
                end
            end
            ST_LAT_COUNT: begin
                if (pat_hit_s) begin
                    rd_latency_d = lat_cnt_q;
                    train_done_d = 1'b1;
                    state_d      = ST_DONE;
                end else if (lat_cnt_q == LAT_LAST) begin
                    train_fail_d = 1'b1;
                    state_d      = ST_FAIL;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // BUSY follows the state being entered so the output is registered
    always_comb begin
        busy_d = 1'b0;
        case (state_d)
            ST_ALIGN, ST_SLIP, ST_SETTLE, ST_LAT_ARM, ST_LAT_COUNT: busy_d = 1'b1;
            default:                                                 busy_d = 1'b0;
        endcase
    end

    // Read valid pipe, tapped at the trained latency
    always_comb begin
        tap_s = 1'b0;
        for (int i = 0; i < RL_MAX; i++) begin
            tap_s = tap_s | (vpipe_q[i] & (rd_latency_q == 4'(i + 1)));
        end

        if (restart_s) begin
            vpipe_d = {RL_MAX{1'b0}};
        end else if (train_done_q) begin
            vpipe_d = {vpipe_q[RL_MAX-2:0], RD_ISSUE};
        end else begin
            vpipe_d = vpipe_q;
        end

        if (train_done_q) begin
            rd_data_d = RX_DATA;
        end else begin
            rd_data_d = rd_data_q;
        end

        // A restart drops anything still in flight, including this cycle's tap
        rd_valid_d = train_done_q & ~restart_s & tap_s;
    end

    // State, counters and registered outputs
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q       <= ST_IDLE;
            slip_cnt_q    <= 3'd0;
            match_cnt_q   <= 4'd0;
            wait_cnt_q    <= 4'd0;
            lat_cnt_q     <= 4'd0;
            rd_latency_q  <= 4'd0;
            train_done_q  <= 1'b0;
            train_fail_q  <= 1'b0;
            busy_q        <= 1'b0;
            rx_bit_slip_q <= 1'b0;
            rd_data_q     <= 8'd0;
            rd_valid_q    <= 1'b0;
            vpipe_q       <= {RL_MAX{1'b0}};
        end else begin
            state_q       <= state_d;
            slip_cnt_q    <= slip_cnt_d;
            match_cnt_q   <= match_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            rd_latency_q  <= rd_latency_d;
            train_done_q  <= train_done_d;
            train_fail_q  <= train_fail_d;
            busy_q        <= busy_d;
            rx_bit_slip_q <= rx_bit_slip_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            vpipe_q       <= vpipe_d;
        end
    end

    assign RX_BIT_SLIP = rx_bit_slip_q;
    assign RD_DATA     = rd_data_q;
    assign RD_VALID    = rd_valid_q;
    assign RD_LATENCY  = rd_latency_q;
    assign TRAIN_DONE  = train_done_q;
    assign TRAIN_FAIL  = train_fail_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_ddr4_rx_lane_aligner.sv
// Directed bench for ddr4_rx_lane_aligner with a small IOD bit-slip model.
module tb_ddr4_rx_lane_aligner;

    localparam logic [7:0] PAT = 8'h3C;

    logic       FAB_CLK;
    logic       ARST_N;
    logic [7:0] RX_DATA;
    logic       TRAIN_START;
    logic       RD_ISSUE;
    logic       RX_BIT_SLIP;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic [3:0] RD_LATENCY;
    logic       TRAIN_DONE;
    logic       TRAIN_FAIL;
    logic       BUSY;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int slips;
    int vcount;
    int phase;
    int last_slip;
    int gap_ok;
    logic exp_v;
    logic [7:0] exp_d;
    logic [16:0] outs_s;

    ddr4_rx_lane_aligner dut (
        .FAB_CLK     (FAB_CLK),
        .ARST_N      (ARST_N),
        .RX_DATA     (RX_DATA),
        .TRAIN_START (TRAIN_START),
        .RD_ISSUE    (RD_ISSUE),
        .RX_BIT_SLIP (RX_BIT_SLIP),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID),
        .RD_LATENCY  (RD_LATENCY),
        .TRAIN_DONE  (TRAIN_DONE),
        .TRAIN_FAIL  (TRAIN_FAIL),
        .BUSY        (BUSY)
    );

    assign outs_s = {RX_BIT_SLIP, RD_DATA, RD_VALID, RD_LATENCY, TRAIN_DONE, TRAIN_FAIL, BUSY};

    initial FAB_CLK = 1'b0;
    always #5 FAB_CLK = ~FAB_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
        return r;
    endfunction

    initial begin
        ARST_N      = 1'b0;
        RX_DATA     = 8'h00;
        TRAIN_START = 1'b0;
        RD_ISSUE    = 1'b0;
        #12;
        check_eq("reset_outs", 32'(outs_s), 32'd0);
        RX_DATA = 8'hAA;
        step();
        step();
        ARST_N = 1'b1;
        step();

        // Reads before any training never become valid
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            RD_ISSUE = (i % 3 == 0);
            step();
            vcount += int'(RD_VALID);
        end
        RD_ISSUE = 1'b0;
        check_eq("pre_train_valid", vcount, 0);
        check_eq("pre_train_done", TRAIN_DONE, 1'b0);

        // Aligned stream: four matches, no slips, waiting for a read
        RX_DATA     = PAT;
        TRAIN_START = 1'b1;
        step();
        TRAIN_START = 1'b0;
        check_eq("busy_after_start", BUSY, 1'b1);
        slips = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            slips += int'(RX_BIT_SLIP);
        end
        RX_DATA = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            slips += int'(RX_BIT_SLIP);
        end
        check_eq("aligned_no_slip", slips, 0);
        check_eq("lat_arm_busy", BUSY, 1'b1);

        // Latency 6; a start pulse and a second read while busy are ignored
        RD_ISSUE = 1'b1;
        step();
        RD_ISSUE = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            TRAIN_START = (k == 2);
            RD_ISSUE    = (k == 3);
            step();
        end
        TRAIN_START = 1'b0;
        RD_ISSUE    = 1'b0;
        check_eq("done_before_hit", TRAIN_DONE, 1'b0);
        RX_DATA = PAT;
        step();
        RX_DATA = 8'h00;
        check_eq("latency_6", RD_LATENCY, 4'd6);
        check_eq("done_lat6", TRAIN_DONE, 1'b1);
        check_eq("busy_lat6", BUSY, 1'b0);
        check_eq("fail_lat6", TRAIN_FAIL, 1'b0);

        // Three back-to-back reads, words A/B/C land at t+6..t+8
        for (int j = 0; j <= 12; j++) begin
            RD_ISSUE = (j < 3);
            case (j)
                6:       RX_DATA = 8'h5A;
                7:       RX_DATA = 8'hA5;
                8:       RX_DATA = 8'h96;
                default: RX_DATA = 8'h00;
            endcase
            exp_d = RX_DATA;
            exp_v = (j >= 6) && (j <= 8);
            step();
            check_eq($sformatf("rd_valid_%0d", j), RD_VALID, exp_v);
            if (exp_v) check_eq($sformatf("rd_data_%0d", j), RD_DATA, exp_d);
        end
        RD_ISSUE = 1'b0;

        // Restart from DONE drops a read in flight
        RX_DATA  = PAT;
        RD_ISSUE = 1'b1;
        step();
        RD_ISSUE = 1'b0;
        step();
        TRAIN_START = 1'b1;
        step();
        TRAIN_START = 1'b0;
        check_eq("restart_done_drop", TRAIN_DONE, 1'b0);
        check_eq("restart_busy", BUSY, 1'b1);
        vcount = 0;
        slips  = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            vcount += int'(RD_VALID);
            slips  += int'(RX_BIT_SLIP);
        end
        check_eq("inflight_dropped", vcount, 0);
        check_eq("realign_no_slip", slips, 0);

        // No pattern within RL_MAX cycles after the read -> fail, latency held
        RX_DATA  = 8'h00;
        RD_ISSUE = 1'b1;
        step();
        RD_ISSUE = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check_eq("fail_before_rlmax", TRAIN_FAIL, 1'b0);
        step();
        check_eq("fail_at_rlmax", TRAIN_FAIL, 1'b1);
        check_eq("fail_lat_held", RD_LATENCY, 4'd6);
        check_eq("fail_busy", BUSY, 1'b0);
        check_eq("fail_done", TRAIN_DONE, 1'b0);

        // Stream rotated by 3 with the IOD slip model
        phase       = 3;
        RX_DATA     = rotr(PAT, phase);
        TRAIN_START = 1'b1;
        slips       = 0;
        last_slip   = -100;
        gap_ok      = 1;
        for (int c = 0; c < 60; c++) begin
            step();
            TRAIN_START = 1'b0;
            if (RX_BIT_SLIP) begin
                if (slips > 0 && (c - last_slip) < 6) gap_ok = 0;
                slips++;
                last_slip = c;
                phase     = (phase + 7) % 8;
            end
            RX_DATA = rotr(PAT, phase);
        end
        check_eq("rot3_slips", slips, 3);
        check_eq("rot3_gap", gap_ok, 1);
        check_eq("rot3_busy", BUSY, 1'b1);
        check_eq("rot3_fail_clr", TRAIN_FAIL, 1'b0);
        RD_ISSUE = 1'b1;
        step();
        RD_ISSUE = 1'b0;
        step();
        check_eq("rot3_latency", RD_LATENCY, 4'd1);
        check_eq("rot3_done", TRAIN_DONE, 1'b1);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            vcount += int'(RD_VALID);
        end
        check_eq("no_stale_valid", vcount, 0);

        // Pattern never presented: seven slips then fail
        RX_DATA     = 8'h00;
        TRAIN_START = 1'b1;
        step();
        TRAIN_START = 1'b0;
        slips = int'(RX_BIT_SLIP);
        for (int c = 0; c < 150; c++) begin
            if (TRAIN_FAIL) break;
            step();
            slips += int'(RX_BIT_SLIP);
        end
        check_eq("nopat_slips", slips, 7);
        check_eq("nopat_fail", TRAIN_FAIL, 1'b1);
        check_eq("nopat_lat_held", RD_LATENCY, 4'd1);
        check_eq("nopat_busy", BUSY, 1'b0);

        // Reset asserted during SETTLE
        TRAIN_START = 1'b1;
        step();
        TRAIN_START = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (RX_BIT_SLIP) break;
            step();
        end
        check_eq("slip_before_reset", RX_BIT_SLIP, 1'b1);
        step();
        step();
        ARST_N = 1'b0;
        #1;
        check_eq("reset_in_settle", 32'(outs_s), 32'd0);
        step();
        ARST_N = 1'b1;
        step();
        step();
        check_eq("after_reset_idle", 32'(outs_s), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
